// File: rtl/key_bounce_gen.sv
// key_bounce_gen: turns clean press/release commands into a bouncing active-low key line
// with LFSR-driven toggle gaps, deterministic from reset.
module key_bounce_gen #(
    parameter int          BOUNCE_CYC = 250_000,
    parameter int          CNT_W      = 20,
    parameter int          GAP_W      = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_press,
    output logic       cmd_ready,
    output logic       key_out,
    output logic       settled,
    output logic       done,
    output logic [7:0] bounce_cnt
);
    localparam int GW = GAP_W + 1;
    typedef enum logic [1:0] {UP, BNC_DN, DOWN, BNC_UP} state_t;
    state_t           r_state, w_state_n;
    logic             r_key, w_key_n, r_done, w_done_n;
    logic [CNT_W-1:0] r_win, w_win_n;
    logic [GW-1:0]    r_gap, w_gap_n, w_gap_ld, w_gap_dec;
    logic [7:0]       r_cnt, w_cnt_n;
    logic [15:0]      r_lfsr;
    logic             w_bnc, w_accept, w_redund;
    assign w_bnc     = (r_state == BNC_DN) || (r_state == BNC_UP);
    assign w_accept  = cmd_valid && !w_bnc;
    assign w_redund  = (r_state == UP) ? !cmd_press : cmd_press;
    assign w_gap_ld  = GW'(r_lfsr[GAP_W-1:0]) + GW'(1);
    assign w_gap_dec = r_gap - GW'(1);
    always_comb begin
        w_state_n = r_state;
        w_key_n   = r_key;
        w_win_n   = r_win;
        w_gap_n   = r_gap;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;
        if (w_accept) begin
            if (w_redund) begin
                w_done_n = 1'b1;
            end else begin
                w_state_n = (r_state == UP) ? BNC_DN : BNC_UP;
                w_key_n   = !r_key;
                w_win_n   = CNT_W'(BOUNCE_CYC - 1);
                w_gap_n   = w_gap_ld;
                w_cnt_n   = 8'd0;
            end
        end else if (w_bnc) begin
            if (r_win == '0) begin
                // final level wins over any toggle due on the expiry edge
                w_state_n = (r_state == BNC_DN) ? DOWN : UP;
                w_key_n   = (r_state == BNC_UP);
                w_done_n  = 1'b1;
            end else begin
                w_win_n = r_win - CNT_W'(1);
                w_gap_n = w_gap_dec;
                if (w_gap_dec == '0) begin
                    w_key_n = !r_key;
                    w_cnt_n = (&r_cnt) ? r_cnt : r_cnt + 8'd1;
                    w_gap_n = w_gap_ld;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UP;
            r_key   <= 1'b1;
            r_win   <= '0;
            r_gap   <= '0;
            r_cnt   <= 8'd0;
            r_done  <= 1'b0;
            r_lfsr  <= SEED;
        end else begin
            r_state <= w_state_n;
            r_key   <= w_key_n;
            r_win   <= w_win_n;
            r_gap   <= w_gap_n;
            r_cnt   <= w_cnt_n;
            r_done  <= w_done_n;
            r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
    assign cmd_ready  = !w_bnc;
    assign settled    = !w_bnc;
    assign key_out    = r_key;
    assign done       = r_done;
    assign bounce_cnt = r_cnt;
endmodule
